// File: rtl/cute_arb_pkg.sv
// Shared definitions for the source-select arbiter.
//   NUM_SRC_DEF / SEL_W_DEF : default source count and select width
//   MAX_SRC                 : widest source vector the arbiter supports
//   arb_state_t             : arbiter FSM states
//   sel_to_onehot()         : select code -> one-hot grant (MAX_SRC wide)
package cute_arb_pkg;

    localparam int NUM_SRC_DEF = 10;
    localparam int SEL_W_DEF   = 4;
    localparam int MAX_SRC     = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [MAX_SRC-1:0] sel_to_onehot(input logic [7:0] s);
        logic [MAX_SRC-1:0] oh;
        oh = '0;
        for (int i = 0; i < MAX_SRC; i++)
            oh[i] = (s == 8'(i));
        return oh;
    endfunction

endpackage

// File: rtl/src_sel_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  : request vector
//   last : most recently served source; scan starts at last+1
//   any  : at least one request is set
//   idx  : first requester found scanning circularly last+1 .. last
module rr_pick
    import cute_arb_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_SRC-1:0] dbl;
    logic [2*NUM_SRC-1:0] masked;

    // Two copies of req side by side: masking off the low copy up to 'last'
    // turns the circular scan into a plain lowest-set-bit search. The upper
    // copy supplies the wrapped-around part, ending at 'last' itself.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int i = 0; i < 2*NUM_SRC; i++)
            masked[i] = dbl[i] && (i > int'(last));
        idx = '0;
        for (int i = 2*NUM_SRC-1; i >= 0; i--)
            if (masked[i])
                idx = (i >= NUM_SRC) ? SEL_W'(i - NUM_SRC) : SEL_W'(i);
        any = |req;
    end

endmodule

// File: rtl/src_sel_arbiter.sv
// src_sel_arbiter: round-robin arbiter driving the select of the 10:1 source mux.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-source request (bit k = source k)
//   ready      : consumer accepts the current beat
//   lock       : burst hold, only when SRC_SEL_LOCK_EN is defined
//   valid      : a source is presented on the bus
//   sel        : mux select {c1,c2,c3,c4}
//   gnt        : one-hot grant, zero when not valid
// Optional feature macro: SRC_SEL_LOCK_EN (adds the lock input).
module src_sel_arbiter
    import cute_arb_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic               ready,
`ifdef SRC_SEL_LOCK_EN
    input  logic               lock,
`endif
    output logic               valid,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] gnt
);

    arb_state_t         state_q;
    logic [SEL_W-1:0]   last_q;
    logic [SEL_W-1:0]   pick_last;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic [MAX_SRC-1:0] pick_oh;
    logic               unused_oh;
    logic               accept;
    logic               lock_hold;
    logic               rotate;

    assign accept = valid & ready;

`ifdef SRC_SEL_LOCK_EN
    // A locked accept keeps the grant only while the owner still requests.
    assign lock_hold = accept & lock & req[sel];
`else
    assign lock_hold = 1'b0;
`endif

    assign rotate = accept & ~lock_hold;

    // On a rotating accept the new pick must already start after the source
    // just served, so feed sel straight in rather than waiting for last_q.
    assign pick_last = rotate ? sel : last_q;

    rr_pick #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_pick (
        .req  (req),
        .last (pick_last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign pick_oh   = sel_to_onehot(8'(pick_idx));
    assign unused_oh = ^pick_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid   <= 1'b0;
            sel     <= '0;
            gnt     <= '0;
            last_q  <= SEL_W'(NUM_SRC - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        sel     <= pick_idx;
                        gnt     <= pick_oh[NUM_SRC-1:0];
                        valid   <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Accept beats withdrawal; withdrawal re-picks without rotating.
                    if (rotate || (!ready && !req[sel])) begin
                        if (rotate)
                            last_q <= sel;
                        if (pick_any) begin
                            sel <= pick_idx;
                            gnt <= pick_oh[NUM_SRC-1:0];
                        end else begin
                            valid   <= 1'b0;
                            gnt     <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_src_sel_arbiter.sv
module tb_src_sel_arbiter;

    localparam int NS = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NS-1:0] req = '0;
    logic          ready = 1'b0;
    logic          lock_i = 1'b0;
    logic          valid;
    logic [3:0]    sel;
    logic [NS-1:0] gnt;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;

    // reference state
    bit  m_valid;
    int  m_sel;
    int  m_last;
    logic lock_eff;

    always #5 clk = ~clk;

    src_sel_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ready (ready),
`ifdef SRC_SEL_LOCK_EN
        .lock  (lock_i),
`endif
        .valid (valid),
        .sel   (sel),
        .gnt   (gnt)
    );

`ifdef SRC_SEL_LOCK_EN
    assign lock_eff = lock_i;
`else
    assign lock_eff = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input bit v, input int s);
        chk({nm, ".valid"}, 32'(valid), 32'(v));
        chk({nm, ".sel"},   32'(sel),   32'(s));
        chk({nm, ".gnt"},   32'(gnt),   v ? (32'd1 << s) : 32'd0);
    endtask

    // First requester found going round from last+1, wrapping, ending at last.
    function automatic int scan(input logic [NS-1:0] r, input int last);
        for (int k = 1; k <= NS; k++)
            if (r[(last + k) % NS]) return (last + k) % NS;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_sel   <= 0;
            m_last  <= NS - 1;
        end else if (!m_valid) begin
            if (req != 0) begin
                m_sel   <= scan(req, m_last);
                m_valid <= 1'b1;
            end
        end else if (ready && lock_eff && req[m_sel]) begin
            // locked burst continues on the same source
        end else if (ready) begin
            m_last <= m_sel;
            if (req != 0) m_sel <= scan(req, m_sel);
            else          m_valid <= 1'b0;
        end else if (!req[m_sel]) begin
            if (req != 0) m_sel <= scan(req, m_last);
            else          m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.valid", 32'(valid), 32'(m_valid));
            chk("model.sel",   32'(sel),   32'(m_sel));
            chk("model.gnt",   32'(gnt),   m_valid ? (32'd1 << m_sel) : 32'd0);
        end
    end

    task automatic do_reset(input logic [NS-1:0] r, input logic rd, input logic lk);
        @(negedge clk);
        rst_n = 1'b0; req = r; ready = rd; lock_i = lk;
        @(negedge clk);
        expect_out("in_reset", 1'b0, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;

        // reset with all requesting, then full rotation
        req = 10'h3FF;
        repeat (3) begin
            @(negedge clk);
            expect_out("rst_hold", 1'b0, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        expect_out("rst_first", 1'b1, 0);
        ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            expect_out("rotate", 1'b1, k % 10);
        end

        // back-pressure
        do_reset(10'h024, 1'b0, 1'b0);
        expect_out("bp_hold", 1'b1, 2);
        repeat (4) begin
            @(negedge clk);
            expect_out("bp_hold", 1'b1, 2);
        end
        ready = 1'b1;
        @(negedge clk);
        expect_out("bp_next", 1'b1, 5);

        // wrap and withdrawal; last must stay 9 across the withdrawal
        do_reset(10'h201, 1'b0, 1'b0);
        expect_out("wrap_first", 1'b1, 0);
        req = 10'h200;
        @(negedge clk);
        expect_out("withdraw", 1'b1, 9);
        req = 10'h003;
        @(negedge clk);
        expect_out("last_kept", 1'b1, 0);

        // single requester then idle
        do_reset(10'h080, 1'b1, 1'b0);
        expect_out("single", 1'b1, 7);
        @(negedge clk);
        expect_out("single", 1'b1, 7);
        @(negedge clk);
        expect_out("single", 1'b1, 7);
        req = '0;
        @(negedge clk);
        expect_out("to_idle", 1'b0, 7);

`ifdef SRC_SEL_LOCK_EN
        do_reset(10'h006, 1'b1, 1'b1);
        expect_out("lock", 1'b1, 1);
        repeat (3) begin
            @(negedge clk);
            expect_out("lock", 1'b1, 1);
        end
        lock_i = 1'b0;
        @(negedge clk);
        expect_out("unlock", 1'b1, 2);
`endif

        // asynchronous reset in the middle of a beat
        do_reset(10'h3FF, 1'b0, 1'b0);
        expect_out("pre_async", 1'b1, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 expect_out("async_rst", 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model
        repeat (3000) begin
            @(negedge clk);
            case ($urandom_range(0, 4))
                0:       req = '0;
                1:       req = NS'(1 << $urandom_range(0, NS - 1));
                2, 3:    req = NS'($urandom);
                default: ;
            endcase
            ready  = ($urandom_range(0, 3) != 0);
            lock_i = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
